// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder: pop-counts stochastic bitstream words and sums them over a frame into a binary count.
// Two stages (popcount register, accumulate); only a frame's last word can stall, on an unaccepted result.
module sc_stream_decoder #(
  parameter int DATA_WIDTH  = 32,
  parameter int FRAME_WORDS = 4,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  bs_valid,
  output logic                  bs_ready,
  input  logic [DATA_WIDTH-1:0] bs_data,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [CNT_WIDTH-1:0]  res_count
);

  localparam int               IDX_W    = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);

  logic [IDX_W-1:0]     r_word_idx;
  logic [CNT_WIDTH-1:0] r_pc_q;
  logic                 r_pc_vld;
  logic                 r_pc_last;
  logic [CNT_WIDTH-1:0] r_acc;
  logic                 r_res_valid;
  logic [CNT_WIDTH-1:0] r_res_count;

  logic                 w_stall;
  logic                 w_in_hs;
  logic                 w_idx_last;
  logic                 w_a_fire;
  logic                 w_a_emit;
  logic [CNT_WIDTH-1:0] w_popcnt;
  logic [CNT_WIDTH-1:0] w_sum;

  // Popcount is zero-extended to the result width; CNT_WIDTH covers a whole frame.
  function automatic logic [CNT_WIDTH-1:0] f_popcount(input logic [DATA_WIDTH-1:0] d);
    logic [CNT_WIDTH-1:0] s;
    s = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      s = s + CNT_WIDTH'(d[i]);
    end
    return s;
  endfunction

  always_comb begin
    w_popcnt = f_popcount(bs_data);
  end

  assign w_stall    = r_pc_vld & r_pc_last & r_res_valid & ~res_ready;
  assign bs_ready   = ~w_stall & ~clear;
  assign w_in_hs    = bs_valid & bs_ready;
  assign w_idx_last = (r_word_idx == LAST_IDX);

  // clear also blocks stage A so a last word caught in stage P is dropped, not emitted.
  assign w_a_fire   = r_pc_vld & ~w_stall & ~clear;
  assign w_a_emit   = w_a_fire & r_pc_last;
  assign w_sum      = r_acc + r_pc_q;

  assign res_valid  = r_res_valid;
  assign res_count  = r_res_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_idx <= '0;
      r_pc_q     <= '0;
      r_pc_vld   <= 1'b0;
      r_pc_last  <= 1'b0;
    end else if (clear) begin
      r_word_idx <= '0;
      r_pc_vld   <= 1'b0;
    end else if (w_in_hs) begin
      r_pc_q     <= w_popcnt;
      r_pc_vld   <= 1'b1;
      r_pc_last  <= w_idx_last;
      r_word_idx <= w_idx_last ? '0 : r_word_idx + IDX_W'(1);
    end else if (!w_stall) begin
      r_pc_vld   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (clear) begin
      r_acc <= '0;
    end else if (w_a_fire) begin
      r_acc <= r_pc_last ? '0 : w_sum;
    end
  end

  // A new result written in the same cycle as an accept keeps res_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_count <= '0;
    end else if (w_a_emit) begin
      r_res_valid <= 1'b1;
      r_res_count <= w_sum;
    end else if (r_res_valid && res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Scoreboard bench for sc_stream_decoder: a frame-sum model pushes expected counts, a monitor pops on accept.
module tb_sc_stream_decoder;

  localparam int DW = 32;
  localparam int FW = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          clear;
  logic          bs_valid;
  logic          bs_ready;
  logic [DW-1:0] bs_data;
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] res_count;

  sc_stream_decoder #(.DATA_WIDTH(DW), .FRAME_WORDS(FW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .bs_valid(bs_valid), .bs_ready(bs_ready), .bs_data(bs_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_count(res_count)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  int exp_q[$];
  int m_sum, m_words;
  bit prev_last;
  int frame_end_cyc, res_cyc, prev_res_cyc, last_res, res_total;
  int vld_samples, rdy_low;
  bit hold_v;
  int hold_c;
  bit rnd_done;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Reference: sum of ones per group of FW accepted words; clear drops the open frame
  // and a frame whose last word was accepted in the cycle just before the clear.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_sum = 0; m_words = 0; prev_last = 0; hold_v = 0;
    end else begin
      if (clear) begin
        if (prev_last && exp_q.size() > 0) void'(exp_q.pop_back());
        m_sum = 0; m_words = 0; prev_last = 0;
      end else if (bs_valid && bs_ready) begin
        m_sum += $countones(bs_data);
        m_words++;
        prev_last = 0;
        if (m_words == FW) begin
          exp_q.push_back(m_sum);
          m_sum = 0; m_words = 0; prev_last = 1;
          frame_end_cyc = cyc;
        end
      end else begin
        prev_last = 0;
      end
      if (bs_valid && !bs_ready) rdy_low++;
      if (res_valid) vld_samples++;
      if (hold_v) begin
        chk("hold_valid", int'(res_valid), 1);
        chk("hold_count", int'(res_count), hold_c);
      end
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_result: got count %0d, expected no result", res_count);
        end else begin
          chk("res_count", int'(res_count), exp_q.pop_front());
        end
        prev_res_cyc = res_cyc;
        res_cyc = cyc;
        last_res = int'(res_count);
        res_total++;
      end
      hold_v = res_valid && !res_ready;
      hold_c = int'(res_count);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [DW-1:0] d);
    int t = 0;
    bs_valid = 1'b1;
    bs_data  = d;
    @(negedge clk);
    while (!bs_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bs_ready) chk("bs_ready_timeout", int'(bs_ready), 1);
    @(posedge clk);
    #1;
    bs_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [DW-1:0] d);
    for (int i = 0; i < FW; i++) send_word(d);
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    case ($urandom_range(0, 3))
      0: w = $urandom;
      1: w = '1;
      2: w = '0;
      default: begin w = '0; w[$urandom_range(0, DW-1)] = 1'b1; end
    endcase
    return w;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int base;
    rst_n = 1'b0; clear = 1'b0; bs_valid = 1'b0; bs_data = '0; res_ready = 1'b1;
    idle(3);
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_res_count", int'(res_count), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_bs_ready", int'(bs_ready), 1);
    idle(1);

    // All-ones frame: 128, one cycle of valid, two cycles after the last handshake
    vld_samples = 0;
    send_frame('1);
    idle(5);
    chk("t1_latency", res_cyc - frame_end_cyc, 2);
    chk("t1_value", last_res, 128);
    chk("t1_valid_cycles", vld_samples, 1);

    // 16-ones words, zero words, mixed words
    send_word(32'h5555_5555); send_word(32'h0F0F_0F0F);
    send_word(32'hFF00_FF00); send_word(32'h3333_3333);
    idle(4);
    chk("half_density", last_res, 64);
    send_frame('0);
    idle(4);
    chk("zero_density", last_res, 0);
    send_word(32'h0000_0001); send_word(32'h8000_0003);
    send_word(32'hFFFF_0000); send_word(32'h0000_0000);
    idle(4);
    chk("mixed_words", last_res, 20);

    // Back-to-back frames
    rdy_low = 0;
    send_frame('1);
    send_frame('0);
    idle(5);
    chk("b2b_no_stall", rdy_low, 0);
    chk("b2b_spacing", res_cyc - prev_res_cyc, 4);
    chk("b2b_last", last_res, 0);

    // Backpressure: first result held, second frame's last word stalls in stage P
    base = res_total;
    res_ready = 1'b0;
    send_frame(32'h0000_00FF);
    send_frame(32'h0000_00FF);
    @(negedge clk);
    chk("bp_ready_drop", int'(bs_ready), 0);
    chk("bp_held_valid", int'(res_valid), 1);
    chk("bp_held_count", int'(res_count), 32);
    idle(1);
    fork
      send_frame(32'h0000_00FF);
      begin
        idle(5);
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_return", int'(bs_ready), 1);
      end
    join
    idle(6);
    chk("bp_result_total", res_total - base, 3);

    // clear mid-frame, then clear right after a last word
    base = res_total;
    send_word('1); send_word('1);
    clear = 1'b1;
    @(negedge clk);
    chk("clear_blocks_input", int'(bs_ready), 0);
    @(posedge clk); #1;
    clear = 1'b0;
    send_frame(32'h0000_000F);
    idle(5);
    chk("clear_mid_value", last_res, 16);
    chk("clear_mid_total", res_total - base, 1);
    base = res_total;
    send_frame(32'h0000_00FF);
    clear = 1'b1;
    idle(1);
    clear = 1'b0;
    idle(4);
    send_frame(32'h0000_0001);
    idle(5);
    chk("clear_last_total", res_total - base, 1);
    chk("clear_last_value", last_res, 4);

    // Async reset mid-frame
    base = res_total;
    send_word(32'h0000_FFFF); send_word(32'h0000_FFFF); send_word(32'h0000_FFFF);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_res_valid", int'(res_valid), 0);
    chk("arst_res_count", int'(res_count), 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < FW; i++) send_word(rnd_word());
    idle(5);
    chk("arst_fresh_total", res_total - base, 1);

    // Random data, random gaps, random res_ready
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 200; i++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
          send_word(rnd_word());
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          res_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    res_ready = 1'b1;
    idle(10);
    chk("rand_drain", exp_q.size(), 0);

    // Random data with random clears
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
      end
      send_word(rnd_word());
    end
    idle(10);
    chk("rand_clear_drain", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
